ps2_key_tracker: RTL

//  Sequences the ps2_rx byte stream into debounced game-control key state.

---
 rtl/ps2_key_tracker.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code sequencer: decodes make/break/extended byte sequences into held levels and press pulses.
// Optional ARROW_KEYS_EN: E0-prefixed left/right arrows also drive the left/right levels.
module ps2_key_tracker #(
  parameter logic [7:0]  LEFT_CODE      = 8'h1C,
  parameter logic [7:0]  RIGHT_CODE     = 8'h1B,
  parameter logic [7:0]  ENTER_CODE     = 8'h5A,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       left,
  output logic       right,
  output logic       enter,
  output logic       left_press,
  output logic       right_press,
  output logic       enter_press,
  output logic       seq_timeout
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM_CNT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] BRK_PFX = 8'hF0;
  localparam logic [7:0] EXT_PFX = 8'hE0;

  typedef enum logic [1:0] {IDLE = 2'd0, BRK = 2'd1, EXT = 2'd2, EXT_BRK = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_held_q, a_held_d, s_held_q, s_held_d, e_held_q, e_held_d;
  logic          la_held_q, la_held_d, ra_held_q, ra_held_d;
  logic          left_q, left_d, right_q, right_d, enter_q, enter_d;
  logic          lp_q, lp_d, rp_q, rp_d, ep_q, ep_d, to_q, to_d;
  logic          do_key_s, do_brk_s, do_ext_s;

  // State, held bits and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_held_q  <= 1'b0;
      s_held_q  <= 1'b0;
      e_held_q  <= 1'b0;
      la_held_q <= 1'b0;
      ra_held_q <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      enter_q   <= 1'b0;
      lp_q      <= 1'b0;
      rp_q      <= 1'b0;
      ep_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_held_q  <= a_held_d;
      s_held_q  <= s_held_d;
      e_held_q  <= e_held_d;
      la_held_q <= la_held_d;
      ra_held_q <= ra_held_d;
      left_q    <= left_d;
      right_q   <= right_d;
      enter_q   <= enter_d;
      lp_q      <= lp_d;
      rp_q      <= rp_d;
      ep_q      <= ep_d;
      to_q      <= to_d;
    end
  end

  // Sequence FSM, idle timeout and key decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_held_d  = a_held_q;
    s_held_d  = s_held_q;
    e_held_d  = e_held_q;
    la_held_d = la_held_q;
    ra_held_d = ra_held_q;
    to_d      = 1'b0;
    do_key_s  = 1'b0;
    do_brk_s  = 1'b0;
    do_ext_s  = 1'b0;

    if (rx_done_tick) begin
      // A byte always wins over a simultaneous terminal count
      cnt_d = '0;
      if (rx_data == EXT_PFX) begin
        state_d = EXT;
      end else if (rx_data == BRK_PFX) begin
        case (state_q)
          IDLE, BRK:    state_d = BRK;
          EXT, EXT_BRK: state_d = EXT_BRK;
          default:      state_d = IDLE;
        endcase
      end else begin
        state_d  = IDLE;
        do_key_s = 1'b1;
        do_brk_s = (state_q == BRK) || (state_q == EXT_BRK);
        do_ext_s = (state_q == EXT) || (state_q == EXT_BRK);
      end
    end else if (state_q != IDLE) begin
      if (cnt_q == TERM_CNT) begin
        state_d = IDLE;
        cnt_d   = '0;
        to_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = '0;
    end

    if (do_key_s && !do_ext_s) begin
      if (rx_data == LEFT_CODE) begin
        a_held_d = !do_brk_s;
      end else if (rx_data == RIGHT_CODE) begin
        s_held_d = !do_brk_s;
      end else if (rx_data == ENTER_CODE) begin
        e_held_d = !do_brk_s;
      end else begin
        a_held_d = a_held_q;
      end
`ifdef ARROW_KEYS_EN
    end else if (do_key_s && do_ext_s) begin
      if (rx_data == 8'h6B) begin
        la_held_d = !do_brk_s;
      end else if (rx_data == 8'h74) begin
        ra_held_d = !do_brk_s;
      end else begin
        la_held_d = la_held_q;
      end
`endif
    end else begin
      a_held_d = a_held_q;
    end

    // Pulses follow the combined level so a second source of the same key stays silent
    left_d  = a_held_d | la_held_d;
    right_d = s_held_d | ra_held_d;
    enter_d = e_held_d;
    lp_d    = left_d  & ~left_q;
    rp_d    = right_d & ~right_q;
    ep_d    = enter_d & ~enter_q;
  end

  assign left        = left_q;
  assign right       = right_q;
  assign enter       = enter_q;
  assign left_press  = lp_q;
  assign right_press = rp_q;
  assign enter_press = ep_q;
  assign seq_timeout = to_q;

endmodule
